// File: rtl/mem_arbiter2.sv
// Two-master arbiter for a picorv32-style native memory port: one transaction
// in flight, registered forwarding, round-robin or fixed priority, slave watchdog.
module mem_arbiter2 #(
    parameter int          PRIORITY       = 0,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TO_RDATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        grant,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam bit          WD_ON   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        winner;
    logic        expire;
    logic [15:0] watchdog;

    // DONE never samples requests, so the owner gets one edge to drop its valid.
    always_comb begin
        winner     = 1'b0;
        expire     = 1'b0;
        state_next = state;
        if (PRIORITY != 0)
            winner = ~m0_valid;
        else if (m0_valid && m1_valid)
            winner = ~last_grant;
        else
            winner = m1_valid;
        expire = WD_ON && (watchdog == WD_LAST);
        case (state)
            IDLE:    if (m0_valid || m1_valid) state_next = BUSY;
            BUSY:    if (s_ready || expire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_valid     <= 1'b0;
            s_instr     <= 1'b0;
            s_addr      <= '0;
            s_wdata     <= '0;
            s_wstrb     <= '0;
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            watchdog    <= '0;
            timeout_err <= 1'b0;
        end else begin
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        s_valid    <= 1'b1;
                        s_instr    <= winner ? m1_instr : m0_instr;
                        s_addr     <= winner ? m1_addr  : m0_addr;
                        s_wdata    <= winner ? m1_wdata : m0_wdata;
                        s_wstrb    <= winner ? m1_wstrb : m0_wstrb;
                        grant      <= winner;
                        last_grant <= winner;
                        watchdog   <= '0;
                    end
                end
                BUSY: begin
                    if (s_ready) begin
                        s_valid <= 1'b0;
                        if (grant) begin
                            m1_rdata <= s_rdata;
                            m1_ready <= 1'b1;
                        end else begin
                            m0_rdata <= s_rdata;
                            m0_ready <= 1'b1;
                        end
                    end else if (expire) begin
                        s_valid     <= 1'b0;
                        timeout_err <= 1'b1;
                        if (grant) begin
                            m1_rdata <= TO_RDATA;
                            m1_ready <= 1'b1;
                        end else begin
                            m0_rdata <= TO_RDATA;
                            m0_ready <= 1'b1;
                        end
                    end else if (watchdog != 16'hFFFF) begin
                        watchdog <= watchdog + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter2.sv
// Bench for mem_arbiter2: instance 0 is round-robin, instance 1 fixed priority,
// both with an 8-cycle watchdog, each behind its own randomly-waiting slave.
module tb_mem_arbiter2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mv [2][2];
    logic        mi [2][2];
    logic [31:0] ma [2][2];
    logic [31:0] mw [2][2];
    logic [3:0]  ms [2][2];
    logic        mr [2][2];
    logic [31:0] mrd [2][2];
    logic        sv [2];
    logic        si [2];
    logic [31:0] sa [2];
    logic [31:0] sw [2];
    logic [3:0]  ss [2];
    logic        sr [2];
    logic [31:0] srd [2];
    logic        grant [2];
    logic        busy [2];
    logic        terr [2];
    logic        hang [2];
    logic [1:0]  swait [2];
    logic [1:0]  scnt [2];
    logic [31:0] smem [2][256];
    logic [31:0] rmem [2][256];
    logic        model_last [2];
    logic [31:0] eq0 [$];
    logic [31:0] eq1 [$];
    bit          dm [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter2 #(.PRIORITY(g), .TIMEOUT_CYCLES(8), .TO_RDATA(32'hDEAD_BEEF)) dut (
            .clk(clk), .resetn(resetn),
            .m0_valid(mv[g][0]), .m0_instr(mi[g][0]), .m0_addr(ma[g][0]),
            .m0_wdata(mw[g][0]), .m0_wstrb(ms[g][0]), .m0_ready(mr[g][0]), .m0_rdata(mrd[g][0]),
            .m1_valid(mv[g][1]), .m1_instr(mi[g][1]), .m1_addr(ma[g][1]),
            .m1_wdata(mw[g][1]), .m1_wstrb(ms[g][1]), .m1_ready(mr[g][1]), .m1_rdata(mrd[g][1]),
            .s_valid(sv[g]), .s_instr(si[g]), .s_addr(sa[g]), .s_wdata(sw[g]), .s_wstrb(ss[g]),
            .s_ready(sr[g]), .s_rdata(srd[g]),
            .grant(grant[g]), .busy(busy[g]), .timeout_err(terr[g])
        );
    end

    function automatic logic [31:0] init_word(int g, int i);
        return 32'h12345678 ^ (32'(i ^ 64) * 32'h00010003) ^ (32'(g) << 28);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Registered slave: answers after 0..3 wait cycles, returns the pre-write word.
    always @(posedge clk or negedge resetn) begin
        for (int g = 0; g < 2; g++) begin
            if (!resetn) begin
                sr[g]    <= 1'b0;
                srd[g]   <= '0;
                scnt[g]  <= '0;
                swait[g] <= '0;
                for (int i = 0; i < 256; i++) smem[g][i] <= init_word(g, i);
            end else if (sr[g]) begin
                sr[g] <= 1'b0;
            end else if (sv[g] && !hang[g]) begin
                if (scnt[g] == swait[g]) begin
                    sr[g]  <= 1'b1;
                    srd[g] <= smem[g][sa[g][9:2]];
                    if (ss[g] != 4'd0)
                        smem[g][sa[g][9:2]] <= merge(smem[g][sa[g][9:2]], sw[g], ss[g]);
                    scnt[g]  <= '0;
                    swait[g] <= 2'($urandom_range(0, 3));
                end else begin
                    scnt[g] <= scnt[g] + 2'd1;
                end
            end
        end
    end

    task automatic init_ref();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 256; i++) rmem[g][i] = init_word(g, i);
            model_last[g] = 1'b1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        init_ref();
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({sv[g], si[g], sa[g], sw[g], ss[g], grant[g], busy[g], terr[g]} !== 72'd0) begin
                errors++;
                $display("[TB] FAIL reset_slave_side dut%0d: got sv=%b addr=%h grant=%b busy=%b terr=%b, expected all 0",
                         g, sv[g], sa[g], grant[g], busy[g], terr[g]);
            end
            checks++;
            if ({mr[g][0], mr[g][1], mrd[g][0], mrd[g][1]} !== 66'd0) begin
                errors++;
                $display("[TB] FAIL reset_master_side dut%0d: got ready=%b%b rdata=%h/%h, expected 0",
                         g, mr[g][0], mr[g][1], mrd[g][0], mrd[g][1]);
            end
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_single_read();
        int p0 = 0;
        int p1 = 0;
        logic [31:0] got = '0;
        @(posedge clk); #1;
        ma[0][0] = 32'h100; ms[0][0] = 4'd0; mi[0][0] = 1'b0; mv[0][0] = 1'b1;
        @(negedge clk);
        checks++;
        if (sv[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_not_yet_forwarded: got s_valid=%b expected 0", sv[0]);
        end
        @(negedge clk);
        checks++;
        if (sv[0] !== 1'b1 || sa[0] !== 32'h100 || grant[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_forward: got s_valid=%b s_addr=%h grant=%b expected 1/00000100/0",
                     sv[0], sa[0], grant[0]);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mr[0][1]) p1++;
            if (mr[0][0]) begin
                p0++;
                got = mrd[0][0];
                @(posedge clk); #1;
                mv[0][0] = 1'b0;
            end
        end
        model_last[0] = 1'b0;
        checks++;
        if (p0 != 1 || p1 != 0) begin
            errors++;
            $display("[TB] FAIL read_ready_pulses: got m0=%0d m1=%0d expected 1/0", p0, p1);
        end
        checks++;
        if (got !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL read_rdata: got %h expected 12345678", got);
        end
        checks++;
        if (mrd[0][0] !== 32'h12345678 || busy[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_rdata_hold: got rdata=%h busy=%b expected 12345678/0", mrd[0][0], busy[0]);
        end
    endtask

    task automatic test_write();
        int p0 = 0;
        int p1 = 0;
        bit seen = 1'b0;
        logic [31:0] old;
        logic [31:0] newv;
        logic [31:0] got = '0;
        old  = rmem[0][16];
        newv = {old[31:16], 16'hA5A5};
        rmem[0][16] = merge(old, 32'hA5A5A5A5, 4'b0011);
        @(posedge clk); #1;
        ma[0][1] = 32'h40; mw[0][1] = 32'hA5A5A5A5; ms[0][1] = 4'b0011; mi[0][1] = 1'b0; mv[0][1] = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = sv[0];
        end
        checks++;
        if (!seen || sa[0] !== 32'h40 || sw[0] !== 32'hA5A5A5A5 || ss[0] !== 4'b0011 || grant[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_forward: got s_valid=%b addr=%h wdata=%h wstrb=%b grant=%b expected 1/00000040/a5a5a5a5/0011/1",
                     sv[0], sa[0], sw[0], ss[0], grant[0]);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mr[0][0]) p0++;
            if (mr[0][1]) begin
                p1++;
                got = mrd[0][1];
                @(posedge clk); #1;
                mv[0][1] = 1'b0;
            end
        end
        model_last[0] = 1'b1;
        checks++;
        if (p1 != 1 || p0 != 0) begin
            errors++;
            $display("[TB] FAIL write_ready_pulses: got m1=%0d m0=%0d expected 1/0", p1, p0);
        end
        checks++;
        if (smem[0][16] !== newv) begin
            errors++;
            $display("[TB] FAIL write_memory: got %h expected %h", smem[0][16], newv);
        end
        checks++;
        if (got !== old) begin
            errors++;
            $display("[TB] FAIL write_rdata: got %h expected %h", got, old);
        end
    endtask

    task automatic drive_master(input int d, input int m, input int n, input bit b2b);
        int idx;
        logic [3:0] st;
        logic [31:0] wd;
        bit got;
        for (int k = 0; k < n; k++) begin
            if (!b2b) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            idx = 128 + m * 64 + int'($urandom_range(0, 63));
            st  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            wd  = $urandom;
            if (m == 0) eq0.push_back(rmem[d][idx]);
            else        eq1.push_back(rmem[d][idx]);
            rmem[d][idx] = merge(rmem[d][idx], wd, st);
            ma[d][m] = 32'(idx) << 2;
            mw[d][m] = wd;
            ms[d][m] = st;
            mi[d][m] = ($urandom_range(0, 1) == 1);
            mv[d][m] = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 400 && !got; c++) begin
                @(negedge clk);
                got = mr[d][m];
            end
            @(posedge clk); #1;
            if (!b2b || k == n - 1 || !got) mv[d][m] = 1'b0;
            if (!got) break;
        end
        dm[m] = 1'b1;
    endtask

    // Grants are predicted from the request pattern the DUT saw at the granting edge.
    task automatic test_traffic(input int d, input int n, input bit b2b);
        int gcount [2];
        int rcount [2];
        eq0.delete();
        eq1.delete();
        dm[0] = 1'b0;
        dm[1] = 1'b0;
        for (int m = 0; m < 2; m++) begin
            gcount[m] = 0;
            rcount[m] = 0;
        end
        @(posedge clk); #1;
        fork
            drive_master(d, 0, n, b2b);
            drive_master(d, 1, n, b2b);
            begin
                int cyc = 0;
                logic psv = 1'b0;
                logic pv [2] = '{1'b0, 1'b0};
                logic pr [2] = '{1'b0, 1'b0};
                logic pi [2] = '{1'b0, 1'b0};
                logic [31:0] pa [2] = '{32'd0, 32'd0};
                logic [31:0] pw [2] = '{32'd0, 32'd0};
                logic [3:0]  ps [2] = '{4'd0, 4'd0};
                logic w;
                logic [31:0] exp;
                while (!(dm[0] && dm[1]) && cyc < 4000) begin
                    @(negedge clk);
                    cyc++;
                    if (sv[d] && !psv) begin
                        if (pv[0] && pv[1]) w = (d == 1) ? 1'b0 : !model_last[d];
                        else                w = pv[1];
                        checks++;
                        if (!(pv[0] || pv[1]) || grant[d] !== w) begin
                            errors++;
                            $display("[TB] FAIL traffic_grant dut%0d: got %b expected %b (req m0=%b m1=%b)",
                                     d, grant[d], w, pv[0], pv[1]);
                        end
                        checks++;
                        if ({sa[d], sw[d], ss[d], si[d]} !== {pa[w], pw[w], ps[w], pi[w]}) begin
                            errors++;
                            $display("[TB] FAIL traffic_forward dut%0d: got addr=%h wdata=%h wstrb=%b instr=%b expected %h/%h/%b/%b",
                                     d, sa[d], sw[d], ss[d], si[d], pa[w], pw[w], ps[w], pi[w]);
                        end
                        model_last[d] = w;
                        gcount[w]++;
                    end
                    for (int m = 0; m < 2; m++) begin
                        if (mr[d][m]) begin
                            rcount[m]++;
                            checks++;
                            if (grant[d] !== 1'(m) || pr[m] || terr[d] !== 1'b0) begin
                                errors++;
                                $display("[TB] FAIL traffic_ready_owner dut%0d m%0d: got grant=%b prev_ready=%b terr=%b expected %0d/0/0",
                                         d, m, grant[d], pr[m], terr[d], m);
                            end
                            exp = 32'hXXXXXXXX;
                            if (m == 0 && eq0.size() > 0) exp = eq0.pop_front();
                            if (m == 1 && eq1.size() > 0) exp = eq1.pop_front();
                            checks++;
                            if (mrd[d][m] !== exp) begin
                                errors++;
                                $display("[TB] FAIL traffic_rdata dut%0d m%0d: got %h expected %h", d, m, mrd[d][m], exp);
                            end
                        end
                    end
                    psv = sv[d];
                    for (int m = 0; m < 2; m++) begin
                        pv[m] = mv[d][m]; pr[m] = mr[d][m]; pi[m] = mi[d][m];
                        pa[m] = ma[d][m]; pw[m] = mw[d][m]; ps[m] = ms[d][m];
                    end
                end
                checks++;
                if (cyc >= 4000) begin
                    errors++;
                    $display("[TB] FAIL traffic_budget dut%0d: got %0d cycles expected fewer than 4000", d, cyc);
                end
            end
        join
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (rcount[m] != n || gcount[m] != n) begin
                errors++;
                $display("[TB] FAIL traffic_counts dut%0d m%0d: got grants=%0d readies=%0d expected %0d each",
                         d, m, gcount[m], rcount[m], n);
            end
        end
    endtask

    task automatic test_timeout();
        int cnt = 0;
        bit seen = 1'b0;
        bit got = 1'b0;
        logic [31:0] exp;
        hang[0] = 1'b1;
        @(posedge clk); #1;
        ma[0][0] = 32'h200; ms[0][0] = 4'd0; mv[0][0] = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = sv[0];
        end
        while (sv[0] && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (!seen || cnt != 8) begin
            errors++;
            $display("[TB] FAIL timeout_busy_cycles: got %0d expected 8", cnt);
        end
        checks++;
        if (mr[0][0] !== 1'b1 || terr[0] !== 1'b1 || mr[0][1] !== 1'b0 || mrd[0][0] !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL timeout_completion: got ready=%b terr=%b m1_ready=%b rdata=%h expected 1/1/0/deadbeef",
                     mr[0][0], terr[0], mr[0][1], mrd[0][0]);
        end
        @(posedge clk); #1;
        mv[0][0] = 1'b0;
        hang[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (terr[0] !== 1'b0 || mr[0][0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_pulse_width: got terr=%b ready=%b expected 0/0", terr[0], mr[0][0]);
        end
        exp = rmem[0][200];
        @(posedge clk); #1;
        ma[0][1] = 32'd800; ms[0][1] = 4'd0; mv[0][1] = 1'b1;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            got = mr[0][1];
        end
        checks++;
        if (!got || mrd[0][1] !== exp || terr[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_recovery: got ready=%b rdata=%h terr=%b expected 1/%h/0", got, mrd[0][1], terr[0], exp);
        end
        @(posedge clk); #1;
        mv[0][1] = 1'b0;
        model_last[0] = 1'b1;
    endtask

    task automatic test_reset_mid_busy();
        bit got = 1'b0;
        bit seen = 1'b0;
        bit b0;
        bit b1;
        int r0 = 0;
        int r1 = 0;
        int spurious = 0;
        // Leave last_grant at m0 so a tie without the reset would go to m1.
        @(posedge clk); #1;
        ma[0][0] = 32'd520; ms[0][0] = 4'd0; mv[0][0] = 1'b1;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            got = mr[0][0];
        end
        @(posedge clk); #1;
        mv[0][0] = 1'b0;
        hang[0] = 1'b1;
        @(posedge clk); #1;
        ma[0][0] = 32'd524; mv[0][0] = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = sv[0];
        end
        repeat (2) @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (!seen || sv[0] !== 1'b0 || busy[0] !== 1'b0 || grant[0] !== 1'b0 || mrd[0][0] !== 32'd0 || mr[0][0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_outputs: got seen=%b sv=%b busy=%b grant=%b rdata=%h ready=%b expected 1/0/0/0/0/0",
                     seen, sv[0], busy[0], grant[0], mrd[0][0], mr[0][0]);
        end
        mv[0][0] = 1'b0;
        init_ref();
        hang[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mr[0][0] || mr[0][1]) spurious++;
        end
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mr[0][0] || mr[0][1]) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("[TB] FAIL reset_no_ready: got %0d ready pulses expected 0", spurious);
        end
        @(posedge clk); #1;
        ma[0][0] = 32'd528; ms[0][0] = 4'd0; mv[0][0] = 1'b1;
        ma[0][1] = 32'd900; ms[0][1] = 4'd0; mv[0][1] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = sv[0];
        end
        checks++;
        if (!seen || grant[0] !== 1'b0 || sa[0] !== 32'd528) begin
            errors++;
            $display("[TB] FAIL first_tie_after_reset: got grant=%b addr=%h expected 0/%h", grant[0], sa[0], 32'd528);
        end
        for (int c = 0; c < 60 && (mv[0][0] || mv[0][1]); c++) begin
            @(negedge clk);
            b0 = mr[0][0];
            b1 = mr[0][1];
            if (b0) r0++;
            if (b1) r1++;
            if (b0 || b1) begin
                @(posedge clk); #1;
                if (b0) mv[0][0] = 1'b0;
                if (b1) mv[0][1] = 1'b0;
            end
        end
        checks++;
        if (r0 != 1 || r1 != 1) begin
            errors++;
            $display("[TB] FAIL post_reset_tie_completion: got m0=%0d m1=%0d expected 1/1", r0, r1);
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            hang[g] = 1'b0;
            for (int m = 0; m < 2; m++) begin
                mv[g][m] = 1'b0; mi[g][m] = 1'b0; ma[g][m] = '0; mw[g][m] = '0; ms[g][m] = '0;
            end
        end
        test_reset();
        test_single_read();
        test_write();
        test_traffic(0, 4, 1'b1);
        test_traffic(1, 3, 1'b1);
        test_traffic(0, 10, 1'b0);
        test_timeout();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_time_limit: got no completion expected finish before 2000000");
        $fatal(1, "[TB] time limit");
    end

endmodule

// File: doc/mem_arbiter2.md
Name: mem_arbiter2

Overview:
- Two-master arbiter sharing the single picorv32-style native memory port (valid/ready/addr/wdata/wstrb/rdata/instr) between two requesters.
  - Typical pairing: CPU core (m0) and the code-decompression prefetch engine (m1).
- One transaction in flight at a time. Registered request forwarding, round-robin or fixed priority, plus a slave-timeout watchdog so a hung slave cannot deadlock the core.

Parameters:
- PRIORITY, 0, 0 = round-robin; 1 = m0 always wins simultaneous requests.
- TIMEOUT_CYCLES, 1024, BUSY cycles before forced completion; 0 disables the watchdog.
- TO_RDATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- m0_valid / m1_valid  in  1  master request, held until that master's ready.
- m0_instr / m1_instr  in  1  request is an instruction fetch.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_wstrb / m1_wstrb  in  4  byte write strobes; 0 = read.
- m0_ready / m1_ready  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  32  read data, valid while that master's ready is high.
- s_valid  out  1  downstream request.
- s_instr  out  1  forwarded instr flag.
- s_addr  out  32  forwarded address.
- s_wdata  out  32  forwarded write data.
- s_wstrb  out  4  forwarded strobes.
- s_ready  in  1  downstream completion.
- s_rdata  in  32  downstream read data.
- grant  out  1  owner of the current or last transaction (0 = m0, 1 = m1).
- busy  out  1  high in BUSY and DONE.
- timeout_err  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset (async, resetn low):
  - state = IDLE.
  - All outputs 0: s_valid, m*_ready, m*_rdata, s_addr, s_wdata, s_wstrb, s_instr, busy, timeout_err.
  - grant = 0; internal last_grant = 1, so m0 wins the first tie.
  - Assertion mid-transaction abandons it; no ready is ever issued for it.
- FSM IDLE, one or both m*_valid high at the edge:
  - Select the winner.
    - PRIORITY = 1: m0 wins.
    - PRIORITY = 0: on a tie, the master != last_grant wins; a single requester always wins.
  - Register the winner's addr/wdata/wstrb/instr into s_*.
  - Set s_valid = 1, grant = winner, last_grant = winner, watchdog = 0, state = BUSY.
- FSM BUSY:
  - s_* held stable; the loser's valid is ignored (it keeps waiting).
  - s_ready high at the edge:
    - s_valid = 0.
    - Owner's m_rdata = s_rdata (captured for writes too) and owner's m_ready = 1.
    - state = DONE.
  - Else if TIMEOUT_CYCLES != 0 and watchdog == TIMEOUT_CYCLES - 1:
    - s_valid = 0.
    - Owner's m_rdata = TO_RDATA, owner's m_ready = 1, timeout_err = 1.
    - state = DONE.
  - Else watchdog increments. The 16-bit counter saturates and never wraps.
- FSM DONE:
  - m*_ready = 0, timeout_err = 0, state = IDLE.
  - New requests are not sampled in DONE. This gives the owner one edge to drop valid, so its held valid is never re-granted.
- Non-owner m_ready is never asserted. Exactly one ready pulse per granted request.
- Latency with a zero-wait combinational slave:
  - m_valid sampled at edge E0 → s_valid from E0.
  - s_ready sampled at E1 → m_ready high E1..E2.
  - IDLE at E3.
  - Back-to-back throughput: one transaction per 3 cycles plus slave wait states.
- m*_rdata holds its value after ready drops until the next completion for that master.
- s_ready seen while not in BUSY is ignored.
- busy = (state != IDLE).

Test Plan:
- Single read, m0 addr 0x100, registered slave returns 0x12345678 → s_addr = 0x100 from the cycle after m0_valid; m0_ready is a single pulse with rdata 0x12345678; m1_ready stays 0; grant = 0.
- Simultaneous m0 and m1 requests, PRIORITY = 0, held for 4 transactions → grants 0,1,0,1; each master sees exactly 2 ready pulses, each with its own address's data.
- Same stimulus with PRIORITY = 1 and both masters re-requesting immediately → m0 wins every tie; m1 is granted only in an IDLE cycle where m0_valid is low.
- m1 write, addr 0x40, wdata 0xA5A5A5A5, wstrb 4'b0011 → s_wstrb = 0011 and s_wdata forwarded unchanged; memory bytes [1:0] updated, upper bytes untouched; m1_ready pulses once.
- TIMEOUT_CYCLES = 8, slave never asserts ready → after 8 BUSY cycles: s_valid falls, m0_ready and timeout_err pulse together, m0_rdata = 0xDEADBEEF; the next request proceeds normally.
- resetn pulled low during BUSY → outputs 0 immediately (async), no ready issued; after release the first tie is granted to m0.
